hop_scheduler: RTL and testbench
================================

# hop_scheduler

Converts raw USB keyboard keycodes from the Nios II keycode PIO into discrete, frame-paced frog hop commands. Each new arrow/WASD press yields exactly one hop. A held key auto-repeats after an initial delay. Hops are delivered to the frog motion logic through a valid/ready handshake. Sits between the `keycode_export` PIO and the frog position module, and uses `VGA_VS` as its frame tick.

## Interface
Parameters:
- `REPEAT_DELAY`, default 20: frames between the first hop and the first auto-repeat hop. Legal range 1..255.
- `REPEAT_RATE`, default 8: frames between subsequent auto-repeat hops. Legal range 1..255.

Ports:
- `Clk` in 1: 50 MHz system clock. Everything is in this one domain.
- `Reset_n` in 1: asynchronous, active-low reset.
- `keycode` in 16: two HID usage codes. Slot 0 is `[7:0]`, slot 1 is `[15:8]`. A value of 0x00 means no key. Synchronous to `Clk`.
- `frame_clk` in 1: `VGA_VS`. Treated as asynchronous.
- `hop_ready` in 1: the frog module can accept a hop.
- `hop_valid` out 1: a hop command is pending.
- `hop_dir` out 2: hop direction. 0 = up, 1 = left, 2 = down, 3 = right.
- `hop_count` out 8: number of completed handshakes. Wraps at 256.

## Operation
- **Keycode register:** `keycode` is registered every cycle into `kc_q`.
- **Decode from `kc_q`:**
  - 0x1A or 0x52 → up.
  - 0x04 or 0x50 → left.
  - 0x16 or 0x51 → down.
  - 0x07 or 0x4F → right.
  - If slot 0 decodes to a direction, slot 0 wins. Otherwise slot 1 is used.
  - Any other code in both slots gives `dir_ok` = 0.
- **Frame tick:** `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detector. The result is a 1-cycle `tick`.
- **Counter:** 8-bit `frame_cnt`.
- **FSM states:**
  - **IDLE.** `hop_valid` = 0. If `dir_ok`, latch the decoded direction into `hop_dir`, load `frame_cnt` = `REPEAT_DELAY`, and go to ISSUE.
  - **ISSUE.** `hop_valid` = 1 and `hop_dir` is held stable. When `hop_valid && hop_ready`, increment `hop_count` and go to HOLD. A key release or key change during ISSUE does not cancel the committed hop. Ticks during ISSUE are ignored and `frame_cnt` is frozen.
  - **HOLD.** `hop_valid` = 0. Checks are applied in this priority order:
    1. If `!dir_ok`, go to IDLE.
    2. Else if the decoded direction differs from `hop_dir`, latch the new direction, load `frame_cnt` = `REPEAT_DELAY`, and go to ISSUE.
    3. Else on `tick`: if `frame_cnt` == 1, load `frame_cnt` = `REPEAT_RATE` and go to ISSUE. Otherwise decrement `frame_cnt`.
- **Boundary rules:**
  - `frame_cnt` never underflows, because it is only decremented when it is 2 or more.
  - `hop_count` wraps from 255 to 0.
- **Reset values, all asynchronous on `Reset_n` low:** state = IDLE, `hop_valid` = 0, `hop_dir` = 0, `hop_count` = 0, `frame_cnt` = 0, `kc_q` = 0, synchronizer flops = 0. Reset mid-handshake drops `hop_valid` immediately. No partial hop is counted.

## Timing
- All outputs are registered.
- **Press latency:** `keycode` is stable before edge k, so `kc_q` updates at k. The FSM enters ISSUE at k+1, so `hop_valid` is high after edge k+1 (2 cycles).
- **Handshake:** the transfer occurs on an edge where `hop_valid && hop_ready`. `hop_valid` is low and `hop_count` is incremented after that same edge.
  - With `hop_ready` held high, `hop_valid` is high for exactly 1 cycle.
  - `hop_valid` never deasserts without a transfer, except on reset.
- **Frame tick latency:** `tick` fires 3 cycles after a `frame_clk` rising edge. There is one tick per VS rising edge.
- **First repeat:** the first repeat `hop_valid` appears 1 cycle after the `REPEAT_DELAY`-th tick following entry to HOLD.
- **Release detection:** key release in HOLD reaches IDLE 2 cycles after `keycode` changes.

## Test plan
1. **Single press:** reset, `hop_ready` = 1, `keycode` = 0x001A for 5 frames then 0x0000 → exactly one handshake, `hop_dir` = 0, `hop_count` = 1. `hop_valid` rises exactly 2 cycles after `keycode` is applied.
2. **Auto-repeat:** `REPEAT_DELAY` = 3, `REPEAT_RATE` = 2, hold `keycode` = 0x0007 for 10 frames → hops at entry and on ticks 3, 5, 7 and 9 after the first handshake (5 total), `hop_dir` = 3, `hop_count` = 5.
3. **Backpressure:** `hop_ready` = 0 for 50 cycles during ISSUE with `keycode` released mid-wait → `hop_valid` and `hop_dir` stay stable. Raising `hop_ready` completes 1 hop, then the FSM returns to IDLE with no repeat.
4. **Two keys and direction change:**
   - `keycode` = 0x0416 → `hop_dir` = 2 (slot 0 priority).
   - Then `keycode` = 0x1600 gives no new hop, since slot 0 is empty and slot 1 is still down.
   - Then `keycode` = 0x0004 → immediate hop with `hop_dir` = 1 and the delay restarted.
5. **Non-game key:** `keycode` = 0x0029 (Esc) → no `hop_valid` for 20 frames.
6. **Reset and wrap:**
   - Assert `Reset_n` = 0 while `hop_valid` = 1 → `hop_valid`, `hop_dir` and `hop_count` go to 0 within the cycle, without waiting for a clock edge.
   - Separately, 256 handshakes → `hop_count` returns to 0.

Source files
------------

// File: rtl/hop_scheduler.sv
// Turns raw HID keycodes into frame-paced frog hop commands (one hop per press, auto-repeat while held).
// Hops are offered on a valid/ready port; the current FSM state is exported on fsm_state for debug.
module hop_scheduler #(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    input  logic        hop_ready,
    output logic        hop_valid,
    output logic [1:0]  hop_dir,
    output logic [7:0]  hop_count,
    output logic [1:0]  fsm_state
);

    // Handshake: a hop transfers on any Clk edge where hop_valid && hop_ready; once raised,
    // hop_valid and hop_dir hold steady until that transfer (only reset can withdraw them).

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] DELAY_LD = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_LD  = 8'(REPEAT_RATE);

    state_t      state, state_nx;
    logic [15:0] kc_q;
    logic [2:0]  fc_sync;
    logic        tick;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic [1:0]  dir_nx;
    logic [7:0]  count_nx;

    // {ok, dir} for one HID usage code
    function automatic logic [2:0] decode(input logic [7:0] code);
        case (code)
            8'h1A, 8'h52: decode = 3'b1_00;
            8'h04, 8'h50: decode = 3'b1_01;
            8'h16, 8'h51: decode = 3'b1_10;
            8'h07, 8'h4F: decode = 3'b1_11;
            default:      decode = 3'b0_00;
        endcase
    endfunction

    logic [2:0] dec0, dec1;
    logic       dir_ok;
    logic [1:0] dec_dir;

    assign dec0    = decode(kc_q[7:0]);
    assign dec1    = decode(kc_q[15:8]);
    assign dir_ok  = dec0[2] | dec1[2];
    assign dec_dir = dec0[2] ? dec0[1:0] : dec1[1:0];

    assign fsm_state = state;

    // VS is asynchronous: two flops to synchronize, a third to find the rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q    <= '0;
            fc_sync <= '0;
            tick    <= 1'b0;
        end else begin
            kc_q    <= keycode;
            fc_sync <= {fc_sync[1:0], frame_clk};
            tick    <= fc_sync[1] & ~fc_sync[2];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            hop_valid <= 1'b0;
            hop_dir   <= 2'd0;
            hop_count <= 8'd0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            hop_valid <= (state_nx == ISSUE);
            hop_dir   <= dir_nx;
            hop_count <= count_nx;
            frame_cnt <= frame_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        dir_nx       = hop_dir;
        count_nx     = hop_count;
        frame_cnt_nx = frame_cnt;
        case (state)
            IDLE: begin
                if (dir_ok) begin
                    dir_nx       = dec_dir;
                    frame_cnt_nx = DELAY_LD;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                // committed hop: key changes and ticks are ignored until it transfers
                if (hop_ready) begin
                    count_nx = hop_count + 8'd1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (!dir_ok) begin
                    state_nx = IDLE;
                end else if (dec_dir != hop_dir) begin
                    dir_nx       = dec_dir;
                    frame_cnt_nx = DELAY_LD;
                    state_nx     = ISSUE;
                end else if (tick) begin
                    if (frame_cnt == 8'd1) begin
                        frame_cnt_nx = RATE_LD;
                        state_nx     = ISSUE;
                    end else if (frame_cnt > 8'd1) begin
                        frame_cnt_nx = frame_cnt - 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hop_scheduler.sv
// Bench for hop_scheduler: directed key/frame scenarios, a behavioural hop model checked every
// cycle, and hand-computed literal expectations at the end of each scenario.
module tb_hop_scheduler;

    localparam int RD = 3;
    localparam int RR = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        frame_clk = 1'b0;
    logic        hop_ready = 1'b0;
    logic        hop_valid;
    logic [1:0]  hop_dir;
    logic [7:0]  hop_count;
    logic [1:0]  fsm_state;

    hop_scheduler #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
        .hop_ready(hop_ready), .hop_valid(hop_valid), .hop_dir(hop_dir),
        .hop_count(hop_count), .fsm_state(fsm_state)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int vseen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 no key held, 1 hop offered, 2 key held waiting for repeat
    typedef struct {
        int          mode;
        logic [1:0]  dir;
        logic [7:0]  hops;
        int          frames;
        logic [15:0] kc_prev;
        logic        fc_prev;
        logic [2:0]  rise_hist;
    } model_t;

    model_t m;

    function automatic int dir_of(input logic [7:0] c);
        case (c)
            8'h1A, 8'h52: return 0;
            8'h04, 8'h50: return 1;
            8'h16, 8'h51: return 2;
            8'h07, 8'h4F: return 3;
            default:      return -1;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.dir = 2'd0; r.hops = 8'd0; r.frames = 0;
        r.kc_prev = 16'h0; r.fc_prev = 1'b0; r.rise_hist = 3'b0;
        return r;
    endfunction

    // keycode is seen one edge late; a VS rise acts on the FSM three edges after it is sampled
    function automatic model_t step(input model_t s, input logic [15:0] kc, input logic fc,
                                    input logic rdy);
        model_t n;
        int d0, d1, d;
        logic tk;
        n  = s;
        d0 = dir_of(s.kc_prev[7:0]);
        d1 = dir_of(s.kc_prev[15:8]);
        d  = (d0 >= 0) ? d0 : d1;
        tk = s.rise_hist[2];
        case (s.mode)
            0: if (d >= 0) begin
                n.dir = 2'(d); n.frames = RD; n.mode = 1;
            end
            1: if (rdy) begin
                n.hops = s.hops + 8'd1; n.mode = 2;
            end
            default: begin
                if (d < 0) n.mode = 0;
                else if (d != int'(s.dir)) begin
                    n.dir = 2'(d); n.frames = RD; n.mode = 1;
                end else if (tk) begin
                    if (s.frames == 1) begin
                        n.frames = RR; n.mode = 1;
                    end else n.frames = s.frames - 1;
                end
            end
        endcase
        n.kc_prev   = kc;
        n.rise_hist = {s.rise_hist[1:0], fc & ~s.fc_prev};
        n.fc_prev   = fc;
        return n;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m <= model_reset();
        else          m <= step(m, keycode, frame_clk, hop_ready);
    end

    always @(negedge Clk) begin
        if (Reset_n === 1'b1)
            chk("cycle {valid,dir,count}", {21'd0, hop_valid, hop_dir, hop_count},
                {21'd0, (m.mode == 1), m.dir, m.hops});
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            if (hop_valid === 1'b1) vseen++;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1; cyc(10);
            frame_clk = 1'b0; cyc(10);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (hop_valid !== 1'b1 && k < budget) begin
            @(negedge Clk);
            k++;
        end
        chk(name, hop_valid, 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int bad;
        cyc(3);
        chk("reset_valid", hop_valid, 0);
        chk("reset_dir", hop_dir, 0);
        chk("reset_count", hop_count, 0);
        chk("reset_state", fsm_state, 0);
        Reset_n = 1'b1;
        cyc(2);

        // single press: valid appears exactly two edges after the key
        hop_ready = 1'b1;
        keycode = 16'h001A;
        @(negedge Clk); chk("t1_lat_edge1", hop_valid, 0);
        @(negedge Clk); chk("t1_lat_edge2", hop_valid, 1);
        chk("t1_dir", hop_dir, 0);
        @(negedge Clk); chk("t1_valid_one_cycle", hop_valid, 0);
        chk("t1_count", hop_count, 1);
        cyc(3); frames(2);
        keycode = 16'h0000; cyc(5);
        chk("t1_count_final", hop_count, 1);

        // auto-repeat: ticks 3,5,7,9 repeat, plus the press hop
        keycode = 16'h0007;
        cyc(6); frames(10);
        chk("t2_count", hop_count, 6);
        chk("t2_dir", hop_dir, 3);
        keycode = 16'h0000; cyc(5);

        // backpressure with release during the wait
        hop_ready = 1'b0;
        keycode = 16'h0051;
        wait_valid("t3_valid_up", 10);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk);
            if (k == 25) keycode = 16'h0000;
            if (hop_valid !== 1'b1 || hop_dir !== 2'd2) bad++;
        end
        chk("t3_stable_cycles_bad", bad, 0);
        hop_ready = 1'b1;
        @(negedge Clk); chk("t3_valid_drop", hop_valid, 0);
        chk("t3_count", hop_count, 7);
        vseen = 0; frames(5);
        chk("t3_no_repeat", vseen, 0);

        // two keys and direction change
        keycode = 16'h0416;
        wait_valid("t4_valid", 10);
        chk("t4_dir_slot0", hop_dir, 2);
        @(negedge Clk); chk("t4_count", hop_count, 8);
        keycode = 16'h1600;
        vseen = 0; cyc(8);
        chk("t4_slot1_same_no_hop", vseen, 0);
        keycode = 16'h0004;
        @(negedge Clk); chk("t4_change_edge1", hop_valid, 0);
        @(negedge Clk); chk("t4_change_edge2", hop_valid, 1);
        chk("t4_dir_left", hop_dir, 1);
        @(negedge Clk); chk("t4_count2", hop_count, 9);
        frames(2);
        chk("t4_delay_restart_2", hop_count, 9);
        frames(1);
        chk("t4_delay_restart_3", hop_count, 10);
        keycode = 16'h0000; cyc(5);

        // non-game key
        keycode = 16'h0029;
        vseen = 0; frames(20);
        chk("t5_no_valid", vseen, 0);
        chk("t5_count", hop_count, 10);
        keycode = 16'h0000; cyc(5);

        // asynchronous reset mid-handshake
        hop_ready = 1'b0;
        keycode = 16'h004F;
        wait_valid("t6_valid", 10);
        chk("t6_dir_pre", hop_dir, 3);
        #3 Reset_n = 1'b0;
        #1;
        chk("t6_async_valid", hop_valid, 0);
        chk("t6_async_dir", hop_dir, 0);
        chk("t6_async_count", hop_count, 0);
        keycode = 16'h0000;
        @(negedge Clk); Reset_n = 1'b1;
        cyc(2);

        // 256 handshakes wrap the counter
        hop_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            keycode = (i % 2 == 1) ? 16'h0004 : 16'h0007;
            cyc(4);
        end
        chk("t6_count_255", hop_count, 255);
        keycode = 16'h0004;
        cyc(4);
        chk("t6_count_wrap", hop_count, 0);
        keycode = 16'h0000;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
